uart_rx_core: RTL

Parametrised UART receive engine that replaces the fixed 8-bit receive control path. It holds, in one block, the oversampling edge counter, the 3-sample majority-vote data sampler, the frame FSM, deserialiser, and parity/stop checkers. New capabilities:
- runtime data width of 5..DW bits;
- even/odd parity selection;
- one or two stop bits;
- early return to IDLE for back-to-back frames.

It sits between the RX pin synchroniser and the RX clock-domain data sync / register file.

---
 rtl/uart_rx_pkg.sv | 7 +
 rtl/uart_rx_sampler.sv | 36 +++
 rtl/uart_rx_core.sv | 120 ++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared state encoding and constants for the UART receive engine
package uart_rx_pkg;
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2} rx_state_e;
   typedef enum logic {PAR_EVEN, PAR_ODD} par_typ_e;
   localparam int MIN_DATA_LEN = 5;
   localparam int SAMPLE_OFS = 2;
endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: per-bit oversampling edge counter and 3-sample majority voter
module uart_rx_sampler
   import uart_rx_pkg::*;
#(
   parameter int PRESC_W = 6
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               rx_in,
   input  logic               start,
   input  logic               clr,
   input  logic [PRESC_W-1:0] presc,
   output logic [PRESC_W-1:0] edge_cnt,
   output logic               bit_wrap,
   output logic               sample_done,
   output logic               sampled_bit
);
   logic [2:0]         smp;
   logic [PRESC_W-1:0] half;
   logic               in_win;
   assign half        = {1'b0, presc[PRESC_W-1:1]};
   assign bit_wrap    = edge_cnt == presc - PRESC_W'(1);
   assign sample_done = edge_cnt == half + PRESC_W'(SAMPLE_OFS);
   assign in_win      = (edge_cnt + PRESC_W'(1) >= half) && (edge_cnt <= half + PRESC_W'(1));
   assign sampled_bit = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);
   // start cycle is edge 0, so a new frame resumes counting at 1
   always_ff @(posedge CLK) begin
      if (RST) begin
         edge_cnt <= '0;
         smp      <= '0;
      end else begin
         edge_cnt <= start ? PRESC_W'(1) : (clr || bit_wrap) ? '0 : edge_cnt + PRESC_W'(1);
         if (in_win) smp <= {smp[1:0], rx_in};
      end
   end
endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: configurable UART frame receiver (FSM, deserialiser, parity/stop checks)
module uart_rx_core
   import uart_rx_pkg::*;
#(
   parameter int DW      = 8,
   parameter int PRESC_W = 6
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               RX_IN,
   input  logic [PRESC_W-1:0] Prescale,
   input  logic [3:0]         DATA_LEN,
   input  logic               PAR_EN,
   input  logic               PAR_TYP,
   input  logic               STOP2,
   output logic [DW-1:0]      P_DATA,
   output logic               data_valid,
   output logic               par_err,
   output logic               stp_err,
   output logic               busy
);
   rx_state_e          state;
   par_typ_e           par_typ_l;
   logic [PRESC_W-1:0] presc_l, presc_c, edge_cnt;
   logic [3:0]         len_l, len_c, bit_idx;
   logic [DW-1:0]      sh;
   logic par_en_l, stop2_l, par_acc, par_bad, stp_bad;
   logic bit_wrap, sample_done, smp_bit;
   logic idle_start, final_dec, start_now, glitch, bad_state, to_idle, stp_now, last, good;
   // out-of-range settings are clamped so the counter and bit index always terminate
   assign presc_c    = (Prescale < PRESC_W'(8)) ? PRESC_W'(8) : Prescale;
   assign len_c      = (DATA_LEN < 4'(MIN_DATA_LEN)) ? 4'(MIN_DATA_LEN) : (DATA_LEN > 4'(DW)) ? 4'(DW) : DATA_LEN;
   assign idle_start = state == S_IDLE && !RX_IN && edge_cnt == '0;
   assign final_dec  = sample_done && (state == S_STOP2 || (state == S_STOP1 && !stop2_l));
   // a start bit already present at the final decision begins the next frame immediately
   assign start_now  = idle_start || (final_dec && !RX_IN);
   assign glitch     = sample_done && state == S_START && smp_bit;
   assign bad_state  = state > S_STOP2;
   assign to_idle    = (state == S_IDLE && !idle_start) || glitch || final_dec || bad_state;
   assign stp_now    = stp_bad || !smp_bit;
   assign good       = !stp_now && !par_bad;
   assign last       = bit_idx == len_l - 4'd1;
   uart_rx_sampler #(.PRESC_W(PRESC_W)) u_sampler (
      .CLK         (CLK),
      .RST         (RST),
      .rx_in       (RX_IN),
      .start       (start_now),
      .clr         (to_idle),
      .presc       (presc_l),
      .edge_cnt    (edge_cnt),
      .bit_wrap    (bit_wrap),
      .sample_done (sample_done),
      .sampled_bit (smp_bit)
   );
   // frame FSM with deserialiser, checkers and registered result pulses
   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= S_IDLE;
         presc_l    <= PRESC_W'(8);
         len_l      <= 4'(MIN_DATA_LEN);
         par_en_l   <= 1'b0;
         par_typ_l  <= PAR_EVEN;
         stop2_l    <= 1'b0;
         bit_idx    <= '0;
         sh         <= '0;
         par_acc    <= 1'b0;
         par_bad    <= 1'b0;
         stp_bad    <= 1'b0;
         P_DATA     <= '0;
         data_valid <= 1'b0;
         par_err    <= 1'b0;
         stp_err    <= 1'b0;
         busy       <= 1'b0;
      end else begin
         data_valid <= final_dec && good;
         par_err    <= final_dec && par_bad;
         stp_err    <= final_dec && stp_now;
         busy       <= start_now || !to_idle;
         if (final_dec && good) P_DATA <= sh;
         if (start_now) begin
            state     <= S_START;
            presc_l   <= presc_c;
            len_l     <= len_c;
            par_en_l  <= PAR_EN;
            par_typ_l <= par_typ_e'(PAR_TYP);
            stop2_l   <= STOP2;
            bit_idx   <= '0;
            sh        <= '0;
            par_acc   <= 1'b0;
            par_bad   <= 1'b0;
            stp_bad   <= 1'b0;
         end else begin
            case (state)
               S_IDLE: ;
               S_START: state <= glitch ? S_IDLE : bit_wrap ? S_DATA : S_START;
               S_DATA: begin
                  if (sample_done) begin
                     sh      <= sh | (DW'(smp_bit) << bit_idx);
                     par_acc <= par_acc ^ smp_bit;
                  end
                  if (bit_wrap) begin
                     bit_idx <= last ? '0 : bit_idx + 4'd1;
                     if (last) state <= par_en_l ? S_PARITY : S_STOP1;
                  end
               end
               S_PARITY: begin
                  if (sample_done) par_bad <= smp_bit != (par_acc ^ (par_typ_l == PAR_ODD));
                  if (bit_wrap) state <= S_STOP1;
               end
               S_STOP1: begin
                  if (sample_done && stop2_l) stp_bad <= !smp_bit;
                  state <= final_dec ? S_IDLE : (bit_wrap && stop2_l) ? S_STOP2 : S_STOP1;
               end
               S_STOP2: state <= final_dec ? S_IDLE : S_STOP2;
               default: state <= S_IDLE;
            endcase
         end
      end
   end
endmodule
